// File: rtl/br_redirect_ctrl_pkg.sv
// Shared types for the PC-relative execute -> writeback/fetch redirect path.
// No logic here: result, address and register types, epoch tag and FSM states.
// Imported by the interface, the output slot and the controller top.
package br_redirect_ctrl_pkg;

  localparam int XLEN            = 32;
  localparam int EPOCH_W_DEFAULT = 2;

  typedef logic [XLEN-1:0]            addr;
  typedef logic [XLEN-1:0]            gpreg;
  typedef logic [EPOCH_W_DEFAULT-1:0] epoch_t;

  // One result from the PC-relative execute unit (AUIPC/JAL/branch).
  typedef struct packed {
    logic [4:0] rd_idx;
    gpreg       rd_val;
    logic       br_valid;
    addr        br_target;
    logic       ex_valid;
  } exec_result;

  // Payload held in the writeback slot.
  typedef struct packed {
    logic [4:0] idx;
    gpreg       val;
  } wb_req;

  // Fetch redirect as seen by the fetch stage.
  typedef struct packed {
    logic valid;
    addr  pc;
  } redirect_req;

  // Controller occupancy: IDLE with nothing pending, BUSY with any slot full.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/br_redirect_ctrl_if.sv
// Bundle of the execute input, writeback output and fetch redirect handshakes.
// slave is the controller side, master is the surrounding pipeline side.
// Widths of the epoch tag and the redirect counter follow the parameters.
interface br_redirect_ctrl_if
  import br_redirect_ctrl_pkg::*;
#(
  parameter int EPOCH_W = EPOCH_W_DEFAULT,
  parameter int CNT_W   = 32
);

  logic               in_valid;
  logic               in_ready;
  exec_result         in_result;
  logic               in_rd_we;
  logic [EPOCH_W-1:0] in_epoch;
  logic [EPOCH_W-1:0] cur_epoch;
  logic               flush;
  logic               wb_valid;
  logic               wb_ready;
  logic [4:0]         wb_idx;
  gpreg               wb_val;
  logic               redirect_valid;
  logic               redirect_ready;
  addr                redirect_pc;
  logic [CNT_W-1:0]   redirect_cnt;

  modport slave (
    input  in_valid, in_result, in_rd_we, in_epoch, wb_ready, redirect_ready,
    output in_ready, cur_epoch, flush, wb_valid, wb_idx, wb_val,
           redirect_valid, redirect_pc, redirect_cnt
  );

  modport master (
    output in_valid, in_result, in_rd_we, in_epoch, wb_ready, redirect_ready,
    input  in_ready, cur_epoch, flush, wb_valid, wb_idx, wb_val,
           redirect_valid, redirect_pc, redirect_cnt
  );

endinterface

// File: rtl/br_redirect_ctrl_br_out_slot.sv
// Single-entry valid/ready holding register for an arbitrary payload type.
// Latency: load at cycle N, out_vld high at N+1; payload changes only on load.
// Backpressure: holds out_vld/out_dat until out_rdy; the owner loads only when free or draining.
module br_out_slot #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  T     load_dat,
  output logic out_vld,
  input  logic out_rdy,
  output T     out_dat
);

  // A load in the same cycle as a drain leaves the slot full with the new payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (load) begin
      out_vld <= 1'b1;
      out_dat <= load_dat;
    end else if (out_vld && out_rdy) begin
      out_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/br_redirect_ctrl.sv
// Filters wrong-path execute results by epoch and issues registered writeback and fetch redirects.
// Latency: accept at N, wb_valid/redirect_valid/flush at N+1; cur_epoch updates at N+1.
// Backpressure: in_ready drops while a full slot is not draining; same-cycle bypass on drain.
module br_redirect_ctrl
  import br_redirect_ctrl_pkg::*;
#(
  parameter int EPOCH_W = EPOCH_W_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  br_redirect_ctrl_if.slave io
);

  ctrl_state_e        state_q;
  ctrl_state_e        state_n;
  logic               in_rdy;
  logic               accept;
  logic               fresh;
  logic               wb_load;
  logic               rd_load;
  logic               wb_pend;
  logic               rd_pend;
  logic               wb_pend_n;
  logic               rd_pend_n;
  wb_req              wb_in;
  wb_req              wb_out;
  addr                rd_pc;
  redirect_req        rd_out;
  logic [EPOCH_W-1:0] epoch_q;
  logic               flush_q;
  logic [CNT_W-1:0]   cnt_q;

  // Stale or exception-marked results are accepted and dropped; the compare uses the
  // epoch before any increment caused by this same accept.
  assign accept  = io.in_valid && in_rdy;
  assign fresh   = accept && (io.in_epoch == epoch_q) && !io.in_result.ex_valid;
  assign wb_load = fresh && io.in_rd_we && (io.in_result.rd_idx != 5'd0);
  assign rd_load = fresh && io.in_result.br_valid;

  assign wb_in.idx = io.in_result.rd_idx;
  assign wb_in.val = io.in_result.rd_val;

  br_out_slot #(.T(wb_req)) u_wb_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (wb_load),
    .load_dat (wb_in),
    .out_vld  (wb_pend),
    .out_rdy  (io.wb_ready),
    .out_dat  (wb_out)
  );

  br_out_slot #(.T(addr)) u_rd_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (rd_load),
    .load_dat (io.in_result.br_target),
    .out_vld  (rd_pend),
    .out_rdy  (io.redirect_ready),
    .out_dat  (rd_pc)
  );

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_n;
  end

  // Next occupancy: BUSY whenever either slot will hold an item next cycle.
  always_comb begin
    wb_pend_n = wb_load || (wb_pend && !io.wb_ready);
    rd_pend_n = rd_load || (rd_pend && !io.redirect_ready);
    state_n   = (wb_pend_n || rd_pend_n) ? ST_BUSY : ST_IDLE;
  end

  // Input ready: always free when idle, otherwise every full slot must drain this cycle.
  always_comb begin
    in_rdy = 1'b1;
    if (state_q == ST_BUSY) begin
      in_rdy = (!wb_pend || io.wb_ready) && (!rd_pend || io.redirect_ready);
    end
  end

  // Epoch advance, one-cycle flush and saturating redirect count on each taken redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      epoch_q <= '0;
      flush_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      flush_q <= rd_load;
      if (rd_load) begin
        epoch_q <= epoch_q + EPOCH_W'(1);
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign rd_out.valid = rd_pend;
  assign rd_out.pc    = rd_pc;

  assign io.in_ready       = in_rdy;
  assign io.cur_epoch      = epoch_q;
  assign io.flush          = flush_q;
  assign io.wb_valid       = wb_pend;
  assign io.wb_idx         = wb_out.idx;
  assign io.wb_val         = wb_out.val;
  assign io.redirect_valid = rd_out.valid;
  assign io.redirect_pc    = rd_out.pc;
  assign io.redirect_cnt   = cnt_q;

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Directed and randomized bench for br_redirect_ctrl against a transaction-level model.
// Counter width is narrowed so saturation is reachable in a short run.
// All expectations come from the model state or from constants below.
module tb_br_redirect_ctrl;
  import br_redirect_ctrl_pkg::*;

  localparam int EW      = 2;
  localparam int CW      = 4;
  localparam int EPOCHS  = 1 << EW;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  br_redirect_ctrl_if #(.EPOCH_W(EW), .CNT_W(CW)) bus ();

  br_redirect_ctrl #(.EPOCH_W(EW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: pending writeback/redirect items plus epoch/counter as plain integers.
  bit   m_wb_pend, m_rd_pend, m_flush;
  int   m_wb_idx, m_epoch, m_cnt;
  gpreg m_wb_val;
  addr  m_pc;
  logic last_rdy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cur_epoch"}, 64'(bus.cur_epoch), 64'(m_epoch));
    chk({tag, ".flush"}, 64'(bus.flush), 64'(m_flush));
    chk({tag, ".wb_valid"}, 64'(bus.wb_valid), 64'(m_wb_pend));
    chk({tag, ".wb_idx"}, 64'(bus.wb_idx), 64'(m_wb_idx));
    chk({tag, ".wb_val"}, 64'(bus.wb_val), 64'(m_wb_val));
    chk({tag, ".redirect_valid"}, 64'(bus.redirect_valid), 64'(m_rd_pend));
    chk({tag, ".redirect_pc"}, 64'(bus.redirect_pc), 64'(m_pc));
    chk({tag, ".redirect_cnt"}, 64'(bus.redirect_cnt), 64'(m_cnt));
  endtask

  // One clock: check in_ready against the model, clock, advance the model, check outputs.
  task automatic tick(input string tag);
    bit exp_rdy, acc;
    #1;
    exp_rdy = (!m_wb_pend || bus.wb_ready) && (!m_rd_pend || bus.redirect_ready);
    last_rdy = bus.in_ready;
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'(exp_rdy));
    acc = bus.in_valid && exp_rdy;
    @(posedge clk);
    if (rst) begin
      m_wb_pend = 0; m_rd_pend = 0; m_flush = 0;
      m_wb_idx = 0; m_wb_val = '0; m_pc = '0; m_epoch = 0; m_cnt = 0;
    end else begin
      if (m_wb_pend && bus.wb_ready) m_wb_pend = 0;
      if (m_rd_pend && bus.redirect_ready) m_rd_pend = 0;
      m_flush = 0;
      if (acc && int'(bus.in_epoch) == m_epoch && !bus.in_result.ex_valid) begin
        if (bus.in_rd_we && bus.in_result.rd_idx != 0) begin
          m_wb_pend = 1;
          m_wb_idx  = int'(bus.in_result.rd_idx);
          m_wb_val  = bus.in_result.rd_val;
        end
        if (bus.in_result.br_valid) begin
          m_rd_pend = 1;
          m_pc      = bus.in_result.br_target;
          m_epoch   = (m_epoch + 1) % EPOCHS;
          m_flush   = 1;
          if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input bit we, input int idx, input gpreg val,
                       input bit br, input addr tgt, input int ep);
    bus.in_valid            = v;
    bus.in_rd_we            = we;
    bus.in_result.rd_idx    = 5'(idx);
    bus.in_result.rd_val    = val;
    bus.in_result.br_valid  = br;
    bus.in_result.br_target = tgt;
    bus.in_result.ex_valid  = 1'b0;
    bus.in_epoch            = EW'(ep);
  endtask

  initial begin
    drive(0, 0, 0, '0, 0, '0, 0);
    bus.wb_ready       = 1'b1;
    bus.redirect_ready = 1'b1;
    m_wb_pend = 0; m_rd_pend = 0; m_flush = 0;
    m_wb_idx = 0; m_wb_val = '0; m_pc = '0; m_epoch = 0; m_cnt = 0;
    @(posedge clk);
    #1;

    // Reset state.
    tick("reset");
    chk("reset.in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset.redirect_cnt", 64'(bus.redirect_cnt), 64'd0);
    rst = 1'b0;

    // AUIPC: writeback only.
    drive(1, 1, 5, 32'h1000, 0, '0, 0);
    tick("auipc");
    chk("auipc.wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("auipc.wb_idx", 64'(bus.wb_idx), 64'd5);
    chk("auipc.wb_val", 64'(bus.wb_val), 64'h1000);
    chk("auipc.redirect_valid", 64'(bus.redirect_valid), 64'd0);
    chk("auipc.flush", 64'(bus.flush), 64'd0);
    drive(0, 0, 0, '0, 0, '0, 0);
    tick("auipc_drain");

    // JAL: writeback and redirect together.
    drive(1, 1, 1, 32'h104, 1, 32'h2000, 0);
    tick("jal");
    chk("jal.wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("jal.redirect_valid", 64'(bus.redirect_valid), 64'd1);
    chk("jal.redirect_pc", 64'(bus.redirect_pc), 64'h2000);
    chk("jal.flush", 64'(bus.flush), 64'd1);
    chk("jal.cur_epoch", 64'(bus.cur_epoch), 64'd1);
    chk("jal.redirect_cnt", 64'(bus.redirect_cnt), 64'd1);
    drive(0, 0, 0, '0, 0, '0, 0);
    tick("jal_after");
    chk("jal_after.flush", 64'(bus.flush), 64'd0);

    // Stale result tagged with the old epoch.
    drive(1, 1, 3, 32'hdead, 1, 32'h9000, 0);
    tick("stale");
    chk("stale.wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("stale.redirect_valid", 64'(bus.redirect_valid), 64'd0);
    chk("stale.cur_epoch", 64'(bus.cur_epoch), 64'd1);
    drive(0, 0, 0, '0, 0, '0, 0);
    tick("stale_after");

    // Branch under redirect backpressure, then bypass accept on drain.
    bus.redirect_ready = 1'b0;
    drive(1, 0, 0, '0, 1, 32'h3000, 1);
    tick("bp_branch");
    drive(1, 0, 0, '0, 1, 32'h4000, 2);
    for (int k = 0; k < 3; k++) begin
      tick("bp_hold");
      chk("bp_hold.in_ready", 64'(last_rdy), 64'd0);
      chk("bp_hold.redirect_pc", 64'(bus.redirect_pc), 64'h3000);
      chk("bp_hold.redirect_valid", 64'(bus.redirect_valid), 64'd1);
    end
    bus.redirect_ready = 1'b1;
    tick("bp_bypass");
    chk("bp_bypass.in_ready", 64'(last_rdy), 64'd1);
    chk("bp_bypass.redirect_pc", 64'(bus.redirect_pc), 64'h4000);
    chk("bp_bypass.cur_epoch", 64'(bus.cur_epoch), 64'd3);
    drive(0, 0, 0, '0, 0, '0, 0);
    tick("bp_after");

    // Fresh reset, then four back-to-back branches wrap the epoch.
    rst = 1'b1;
    tick("reset2");
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, '0, 1, addr'(32'h100 * (k + 1)), k);
      tick("wrap");
      chk("wrap.cur_epoch", 64'(bus.cur_epoch), 64'((k + 1) % 4));
      chk("wrap.flush", 64'(bus.flush), 64'd1);
    end
    chk("wrap.redirect_cnt", 64'(bus.redirect_cnt), 64'd4);

    // Drive the counter into saturation and past it.
    for (int k = 0; k < 13; k++) begin
      drive(1, 0, 0, '0, 1, addr'(32'h8000 + k), m_epoch);
      tick("sat");
    end
    chk("sat.redirect_cnt", 64'(bus.redirect_cnt), 64'(CNT_MAX));
    drive(0, 0, 0, '0, 0, '0, 0);
    tick("sat_after");

    // Reset with both slots pending.
    bus.wb_ready       = 1'b0;
    bus.redirect_ready = 1'b0;
    drive(1, 1, 7, 32'h77, 1, 32'h5000, m_epoch);
    tick("both_pend");
    chk("both_pend.wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("both_pend.redirect_valid", 64'(bus.redirect_valid), 64'd1);
    drive(0, 0, 0, '0, 0, '0, 0);
    rst = 1'b1;
    tick("mid_reset");
    chk("mid_reset.wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("mid_reset.redirect_valid", 64'(bus.redirect_valid), 64'd0);
    chk("mid_reset.wb_val", 64'(bus.wb_val), 64'd0);
    chk("mid_reset.redirect_pc", 64'(bus.redirect_pc), 64'd0);
    chk("mid_reset.cur_epoch", 64'(bus.cur_epoch), 64'd0);
    chk("mid_reset.in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst                     = ($urandom_range(0, 149) == 0);
      bus.in_valid            = ($urandom_range(0, 3) != 0);
      bus.wb_ready            = ($urandom_range(0, 3) != 0);
      bus.redirect_ready      = ($urandom_range(0, 2) != 0);
      bus.in_rd_we            = $urandom_range(0, 1) == 1;
      bus.in_result.rd_idx    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.in_result.rd_val    = $urandom;
      bus.in_result.br_valid  = $urandom_range(0, 1) == 1;
      bus.in_result.br_target = $urandom;
      bus.in_result.ex_valid  = ($urandom_range(0, 15) == 0);
      bus.in_epoch            = ($urandom_range(0, 2) == 0) ? EW'($urandom_range(0, EPOCHS - 1))
                                                            : EW'(m_epoch);
      tick("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/br_redirect_ctrl.md
Name: br_redirect_ctrl

Overview:
- Sits between the PC-relative execute unit (AUIPC/JAL/branch) and the writeback and fetch stages.
- Accepts one exec_result per handshake and discards wrong-path results using an epoch tag.
- Drives a registered writeback request and a registered fetch redirect, each with its own valid/ready handshake.
- On every accepted taken branch or jump it advances the epoch and pulses flush to squash younger in-flight work.

Parameters:
- EPOCH_W, 2, width of the wrong-path epoch tag; wraps modulo 2^EPOCH_W.
- CNT_W, 32, width of the saturating redirect performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  execute result valid.
- in_ready  out  1  controller can accept a result.
- in_result  in  exec_result  rd_idx, rd_val, br_valid, br_target, ex_valid fields.
- in_rd_we  in  1  result writes rd (AUIPC/JAL = 1, branch = 0).
- in_epoch  in  EPOCH_W  epoch captured at decode.
- cur_epoch  out  EPOCH_W  current epoch, sampled by decode.
- flush  out  1  one-cycle pulse: squash all in-flight instructions tagged with the old epoch.
- wb_valid  out  1  writeback request pending.
- wb_ready  in  1  writeback accepted.
- wb_idx  out  5  destination register.
- wb_val  out  gpreg  destination value.
- redirect_valid  out  1  fetch redirect pending.
- redirect_ready  in  1  fetch accepted redirect.
- redirect_pc  out  addr  new fetch PC.
- redirect_cnt  out  CNT_W  number of redirects issued, saturating.

Behaviour:
- Reset (sync, rst=1 at posedge): cur_epoch=0, wb_valid=0, redirect_valid=0, flush=0, redirect_cnt=0, wb_idx=0, wb_val=0, redirect_pc=0. Reset asserted mid-operation drops any pending wb/redirect with no handshake completion.
- Internal state: two pending flags, wb_pend and rd_pend. FSM view:
  - IDLE: both flags clear.
  - BUSY: at least one flag set.
  - Each flag clears independently when its handshake fires (valid & ready).
- in_ready = (!wb_pend || wb_ready) && (!rd_pend || redirect_ready). This is a same-cycle bypass: a new result may be accepted in the cycle the last pending item drains.
- in_ready does not depend on in_result or in_epoch.
- Accept = in_valid & in_ready. On accept:
  - stale (in_epoch != cur_epoch): result dropped. No wb, no redirect, no flush, epoch unchanged. Pending flags only drain.
  - ex_valid=1 (not produced today, defined for safety): treated as stale drop.
  - wb: sets wb_pend (wb_valid=1 next cycle) and loads wb_idx/wb_val when in_rd_we=1 and rd_idx!=0. rd_idx=0 with in_rd_we=1 produces no writeback.
  - br_valid=1:
    - sets rd_pend and loads redirect_pc=br_target.
    - increments cur_epoch modulo 2^EPOCH_W; new value is visible the next cycle.
    - flush=1 for exactly the next cycle.
    - redirect_cnt += 1 unless it equals all-ones.
  - A JAL sets both wb and redirect in the same accept.
- Latency: accept at cycle N; wb_valid/redirect_valid/flush high at N+1.
- Outputs are registers only, with no combinational path from in_* to wb_*/redirect_*.
- wb_valid and redirect_valid hold, with stable payload, until their handshake. Payload registers load only on accept.
- Simultaneous events:
  - Drain and new accept in the same cycle: the flag ends set with new payload.
  - Redirect and flush in the same cycle as a stale input: the input is still dropped against the pre-increment epoch.
- Epoch wrap: after 2^EPOCH_W redirects the epoch returns to 0. Decode guarantees at most 2^EPOCH_W-1 epochs in flight.

Decomposition:
- Shared types package (alongside exec_result, addr, gpreg) gets:
  - the epoch typedef, sized by a package constant EPOCH_W_DEFAULT=2;
  - a redirect_req struct {valid, pc}.
- One natural sub-module: br_out_slot, a single-entry valid/ready holding register parameterised by payload type. It is instantiated twice, for wb and for redirect.
- Epoch, flush and counter logic stay in the top module.

Test Plan:
- Reset, then AUIPC result (rd_idx=5, rd_val=0x1000, in_rd_we=1, epoch 0), wb_ready=1 → wb_valid one cycle later with idx 5 / val 0x1000; no redirect; flush=0; epoch stays 0.
- JAL (rd_idx=1, rd_val=0x104, br_valid=1, br_target=0x2000) → at N+1: wb_valid, redirect_valid with pc 0x2000, flush=1 for one cycle; cur_epoch=1; redirect_cnt=1.
- After that JAL, a result tagged epoch 0 → accepted and dropped: no wb_valid, no redirect, epoch stays 1.
- Taken branch (in_rd_we=0, br_valid=1) with redirect_ready=0 for 3 cycles → redirect_valid and pc held stable, in_ready=0 throughout; redirect_ready=1 in cycle 4 with a new in_valid → accepted that same cycle (bypass).
- Four consecutive taken branches with EPOCH_W=2 → cur_epoch sequence 1,2,3,0; flush pulses 4 times; redirect_cnt=4. Separately, preload redirect_cnt at all-ones → stays at all-ones.
- rst asserted while wb_pend and rd_pend are both set → next cycle all outputs 0, cur_epoch=0, in_ready=1.
